// File: rtl/ahb_keypad_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_keypad_slave
//  Purpose  : AHB-Lite slave exposing the keypad key code and a CLEAR
//             acknowledge that pulses key_clear to the scanner.
//             Optional macro AHB_KPD_ERR_RESP_EN adds two-cycle ERROR
//             responses for illegal-direction accesses.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_keypad_slave (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [3:0]  HPROT,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    input  logic [15:0] key_data,
    output logic        key_clear
);

    localparam logic [1:0]  c_OFS_DATA  = 2'd0;
    localparam logic [1:0]  c_OFS_CLEAR = 2'd1;
    localparam logic [1:0]  c_OFS_LAST  = 2'd2;
    localparam logic [31:0] c_ID_VALUE  = 32'h4B42_0001;

    logic        r_dp_valid;
    logic        r_dp_write;
    logic [1:0]  r_dp_addr;
    logic [15:0] r_last;
    logic [31:0] r_hrdata;
    logic        r_key_clear;

    logic        w_accept;
    logic        w_err_req;
    logic        w_clear_hit;
    logic [31:0] w_rd_mux;
    logic        w_unused_ok;

    assign w_accept    = HSEL & HTRANS[1] & HREADY;
    assign w_clear_hit = r_dp_valid & r_dp_write & (r_dp_addr == c_OFS_CLEAR) & HWDATA[0];
    assign w_unused_ok = ^{HPROT, HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:1]};

    always_comb begin
        w_rd_mux = 32'h0;
        case (HADDR[3:2])
            c_OFS_DATA:  w_rd_mux = {16'h0, key_data};
            c_OFS_CLEAR: w_rd_mux = 32'h0;
            c_OFS_LAST:  w_rd_mux = {16'h0, r_last};
            default:     w_rd_mux = c_ID_VALUE;
        endcase
    end

    // Read data is captured on the address-phase edge so DATA reflects the
    // key code seen in that cycle; LAST is read before any concurrent update.
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            r_dp_valid  <= 1'b0;
            r_dp_write  <= 1'b0;
            r_dp_addr   <= 2'd0;
            r_last      <= 16'h0;
            r_hrdata    <= 32'h0;
            r_key_clear <= 1'b0;
        end else begin
            if (HREADY) begin
                r_dp_valid <= w_accept;
                if (w_accept) begin
                    r_dp_write <= HWRITE;
                    r_dp_addr  <= HADDR[3:2];
                end
            end
            r_key_clear <= w_clear_hit;
            if (w_clear_hit) begin
                r_last <= key_data;
            end
            if (w_accept && !HWRITE && !w_err_req) begin
                r_hrdata <= w_rd_mux;
            end
        end
    end

    assign HRDATA    = r_hrdata;
    assign key_clear = r_key_clear;

`ifdef AHB_KPD_ERR_RESP_EN
    localparam logic [1:0] c_ST_OKAY = 2'd0;
    localparam logic [1:0] c_ST_ERR1 = 2'd1;
    localparam logic [1:0] c_ST_ERR2 = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    // Writes to read-only registers and reads of the write-only CLEAR.
    assign w_err_req = w_accept & (HWRITE ? (HADDR[3:2] != c_OFS_CLEAR)
                                          : (HADDR[3:2] == c_OFS_CLEAR));

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            r_state <= c_ST_OKAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = c_ST_OKAY;
        case (r_state)
            c_ST_ERR1: w_state_nxt = c_ST_ERR2;
            default:   w_state_nxt = w_err_req ? c_ST_ERR1 : c_ST_OKAY;
        endcase
    end

    assign HREADYOUT = (r_state != c_ST_ERR1);
    assign HRESP     = (r_state != c_ST_OKAY);
`else
    assign w_err_req = 1'b0;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_keypad_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_keypad_slave
//  Purpose  : Self-checking bench for ahb_keypad_slave: directed register-map
//             accesses followed by random pipelined traffic vs a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_keypad_slave;

    localparam logic [31:0] c_ID_VALUE = 32'h4B42_0001;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [15:0] key_data;
    logic        key_clear;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: transaction-level view of the slave.
    logic [15:0] m_last;
    logic [31:0] m_rdata;
    logic        m_clear;
    int          m_err_stage;
    logic        m_dp_valid;
    logic        m_dp_write;
    logic [1:0]  m_dp_ofs;

    assign HREADY = HREADYOUT;

    ahb_keypad_slave u_dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HPROT     (HPROT),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .key_data  (key_data),
        .key_clear (key_clear)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic is_illegal(input logic wr, input logic [1:0] ofs);
`ifdef AHB_KPD_ERR_RESP_EN
        return wr ? (ofs != 2'd1) : (ofs == 2'd1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_last      = 16'h0;
        m_rdata     = 32'h0;
        m_clear     = 1'b0;
        m_err_stage = 0;
        m_dp_valid  = 1'b0;
        m_dp_write  = 1'b0;
        m_dp_ofs    = 2'd0;
    endtask

    // One bus cycle: check what the previous edge produced, then present
    // new address-phase / data-phase inputs and predict the next edge.
    task automatic step(input logic rst, input logic sel, input logic [1:0] trans,
                        input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [15:0] kd);
        logic       ready;
        logic       accept;
        logic       hit_clear;
        logic [1:0] ofs;
        @(negedge HCLK);
        check_eq("hrdata",    HRDATA,           m_rdata);
        check_eq("hreadyout", {31'h0, HREADYOUT}, {31'h0, m_err_stage != 1});
        check_eq("hresp",     {31'h0, HRESP},     {31'h0, m_err_stage != 0});
        check_eq("key_clear", {31'h0, key_clear}, {31'h0, m_clear});
        HRESETn  = rst;
        HSEL     = sel;
        HTRANS   = trans;
        HADDR    = addr;
        HWRITE   = wr;
        HWDATA   = wd;
        key_data = kd;
        HPROT    = 4'($urandom);
        HSIZE    = 3'($urandom);
        if (rst) begin
            model_reset();
        end else begin
            ofs       = addr[3:2];
            ready     = (m_err_stage != 1);
            accept    = sel && trans[1] && ready;
            hit_clear = m_dp_valid && m_dp_write && (m_dp_ofs == 2'd1) && wd[0];
            if (accept && !wr && !is_illegal(wr, ofs)) begin
                case (ofs)
                    2'd0:    m_rdata = {16'h0, kd};
                    2'd1:    m_rdata = 32'h0;
                    2'd2:    m_rdata = {16'h0, m_last};
                    default: m_rdata = c_ID_VALUE;
                endcase
            end
            if (hit_clear) m_last = kd;
            m_clear = hit_clear;
            if (m_err_stage == 1)                        m_err_stage = 2;
            else if (accept && is_illegal(wr, ofs))      m_err_stage = 1;
            else                                         m_err_stage = 0;
            if (ready) begin
                m_dp_valid = accept;
                if (accept) begin
                    m_dp_write = wr;
                    m_dp_ofs   = ofs;
                end
            end
        end
    endtask

    task automatic idle(input logic [31:0] wd, input logic [15:0] kd);
        step(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, wd, kd);
    endtask

    initial begin
        HRESETn  = 1'b1;
        HSEL     = 1'b0;
        HTRANS   = 2'b00;
        HADDR    = 32'h0;
        HWRITE   = 1'b0;
        HWDATA   = 32'h0;
        HPROT    = 4'h0;
        HSIZE    = 3'h2;
        key_data = 16'h0;
        model_reset();

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 16'h0);
        idle(32'h0, 16'h1234);
        step(1'b0, 1'b1, 2'b10, 32'h8, 1'b0, 32'h0, 16'h1234);     // LAST after reset
        idle(32'h0, 16'h1234);
        step(1'b0, 1'b1, 2'b10, 32'h0, 1'b0, 32'h0, 16'hFFFE);     // DATA read
        idle(32'h0, 16'h0000);
        step(1'b0, 1'b1, 2'b10, 32'h4, 1'b1, 32'h0, 16'hFFF9);     // CLEAR write
        idle(32'h1, 16'hFFF9);
        step(1'b0, 1'b1, 2'b10, 32'h8, 1'b0, 32'h0, 16'h0AAA);     // LAST read
        idle(32'h0, 16'h0AAA);
        step(1'b0, 1'b1, 2'b10, 32'h4, 1'b1, 32'h0, 16'h5555);     // CLEAR with 0
        idle(32'h0, 16'h5555);
        step(1'b0, 1'b1, 2'b11, 32'hC, 1'b0, 32'h0, 16'h5555);     // ID read
        idle(32'h0, 16'h5555);
        step(1'b0, 1'b0, 2'b10, 32'h4, 1'b1, 32'h0, 16'h7777);     // unselected
        idle(32'h1, 16'h7777);
        step(1'b0, 1'b1, 2'b00, 32'h4, 1'b1, 32'h0, 16'h7777);     // IDLE transfer
        idle(32'h1, 16'h7777);
        step(1'b0, 1'b1, 2'b10, 32'h0, 1'b1, 32'h0, 16'h3333);     // write DATA
        idle(32'hFFFF_FFFF, 16'h3333);
        idle(32'h0, 16'h3333);
        idle(32'h0, 16'h3333);
        step(1'b0, 1'b1, 2'b10, 32'h8, 1'b0, 32'h0, 16'h3333);
        idle(32'h0, 16'h3333);
        step(1'b0, 1'b1, 2'b10, 32'h4, 1'b1, 32'h0, 16'hBEEF);     // back-to-back CLEAR
        step(1'b0, 1'b1, 2'b11, 32'h4, 1'b1, 32'h1, 16'hBEEF);
        step(1'b0, 1'b1, 2'b10, 32'h8, 1'b0, 32'h1, 16'hCAFE);
        idle(32'h0, 16'h0101);
        step(1'b0, 1'b1, 2'b10, 32'h4, 1'b1, 32'h0, 16'hD00D);     // reset mid-transfer
        step(1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 32'h1, 16'hD00D);
        idle(32'h0, 16'hD00D);
        idle(32'h0, 16'hD00D);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) != 0),
                 2'($urandom),
                 $urandom,
                 1'($urandom),
                 ($urandom_range(0, 1) == 1) ? $urandom : {$urandom} & 32'hFFFF_FFFE,
                 16'($urandom));
        end
        idle(32'h0, 16'h0);
        idle(32'h0, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_keypad_slave.md
# ahb_keypad_slave

AHB-Lite slave that exposes the keypad scanner's decoded key code to the Cortex-M0 and lets firmware acknowledge a keypress. It sits on one interconnect port, between the AHB-Lite decoder and the keypad scanner. Firmware reads the current key code, reads the code captured at the last acknowledge, and writes an acknowledge that pulses `key_clear` to the scanner.

## Interface
- No parameters.
- Clock and reset: one clock; reset is synchronous and active-high.
- `HCLK` — in — 1 — single system clock; all logic is on its rising edge.
- `HRESETn` — in — 1 — synchronous active-high reset; 1 = reset. The port name is kept for codebase consistency.
- `HSEL` — in — 1 — slave select from the decoder.
- `HADDR` — in — 32 — address; only `HADDR[3:2]` is decoded.
- `HPROT` — in — 4 — ignored.
- `HSIZE` — in — 3 — ignored; every access is treated as a 32-bit word.
- `HTRANS` — in — 2 — a transfer is valid when `HTRANS[1]`=1 (NONSEQ or SEQ).
- `HWDATA` — in — 32 — write data, sampled in the data phase.
- `HWRITE` — in — 1 — 1 = write.
- `HREADY` — in — 1 — bus-wide ready.
- `HRDATA` — out — 32 — read data.
- `HREADYOUT` — out — 1 — slave ready.
- `HRESP` — out — 1 — 0 = OKAY, 1 = ERROR.
- `key_data` — in — 16 — decoded key code from the scanner; may change at any cycle.
- `key_clear` — out — 1 — one-cycle acknowledge pulse to the scanner.

## Operation
- Address phase is accepted when `HSEL & HTRANS[1] & HREADY`. On acceptance, register a valid flag, the write flag and `HADDR[3:2]`.
- Register map (offset = `HADDR[3:2]`×4):
  - 0x0 DATA (RO): `{16'h0, key_data}`.
  - 0x4 CLEAR (WO): a write with `HWDATA[0]`=1 pulses `key_clear` and copies `key_data` into LAST. A write with `HWDATA[0]`=0 has no effect. Reads return 0.
  - 0x8 LAST (RO): `{16'h0, LAST}`.
  - 0xC ID (RO): constant `32'h4B42_0001`.
- Writes to RO registers are ignored; the response is OKAY unless the macro below is defined.
- Idle or unselected cycles leave all state unchanged.

## Timing
- Zero wait states: `HREADYOUT`=1 in every data phase, except for error responses.
- Read data:
  - `HRDATA` comes from a register loaded on the address-phase edge.
  - For DATA, the returned value is `key_data` as sampled in the address-phase cycle.
  - `HRDATA` holds its value until the next accepted read.
- CLEAR write:
  - `HWDATA` is sampled during the data-phase cycle.
  - `key_clear` is registered: it is 1 for exactly one cycle, the cycle after the data phase.
  - LAST updates on the same edge that sets `key_clear`.
  - Back-to-back CLEAR writes produce back-to-back pulses, one per write.
- No forwarding: a LAST read whose address phase coincides with a CLEAR data phase returns the pre-clear LAST.
- Reset values: `HRDATA`=0, `HREADYOUT`=1, `HRESP`=0, `key_clear`=0, LAST=0, pending address-phase state cleared.
- Reset asserted mid-transfer aborts the transfer; no pulse is produced.

## Configuration
- Macro: `AHB_KPD_ERR_RESP_EN`.
- Defined: a write to DATA, LAST or ID, or a read of CLEAR, gets an AHB two-cycle ERROR response.
  - Cycle 1: `HREADYOUT`=0, `HRESP`=1.
  - Cycle 2: `HREADYOUT`=1, `HRESP`=1.
  - No state changes and no `key_clear` pulse.
- Undefined: all such accesses complete with OKAY, zero wait; reads of CLEAR return 0.

## Test plan
- Reset: hold `HRESETn`=1 for 3 cycles, then release → `HRDATA`=0, `HREADYOUT`=1, `HRESP`=0, `key_clear`=0; a LAST read returns 0.
- Read DATA with `key_data`=16'hFFFE → `HRDATA`=32'h0000_FFFE in the data phase, zero wait.
- Write `HWDATA`=1 to CLEAR with `key_data`=16'hFFF9 → `key_clear` high for exactly one cycle after the data phase; a following LAST read returns 32'h0000_FFF9.
- Write `HWDATA`=0 to CLEAR → no `key_clear` pulse; LAST unchanged.
- Read ID → 32'h4B42_0001. An access with `HSEL`=0 or `HTRANS`=IDLE → no state change and no pulse.
- Write to DATA:
  - With `AHB_KPD_ERR_RESP_EN` defined → two-cycle ERROR response and DATA/LAST unchanged.
  - Without it → OKAY response and DATA/LAST unchanged.
